axis_udp_payload_buffer: RTL and testbench
==========================================

Name: axis_udp_payload_buffer

Overview:
Store-and-forward AXI-Stream frame buffer placed directly downstream of udp_filter. It consumes the filtered UDP payload stream and releases a frame to the consumer only after that frame's tlast has been stored. Frames that do not fit in the free space are discarded whole, so no partial frame ever leaves the block. Input is never back-pressured, which keeps the upstream filter running at line rate.

Parameters:
STREAM_DATA_WIDTH, 32, tdata width in bits; must be a multiple of 8.
ADDR_WIDTH, 9, log2 of buffer depth in beats. The default gives 512 beats, which covers PAYLOAD_MAX_SIZE 1600 bytes at 32 bits.
TKEEP_WIDTH, STREAM_DATA_WIDTH/8, derived; do not override.

Ports:
clk_i  in  1  clock
s_rst_n_i  in  1  reset, asynchronous, active-low
s_axis_tdata_i  in  STREAM_DATA_WIDTH  payload from udp_filter
s_axis_tkeep_i  in  TKEEP_WIDTH  byte enables
s_axis_tvalid_i  in  1  input beat valid
s_axis_tlast_i  in  1  last beat of frame
s_axis_tready_o  out  1  input ready
m_axis_tdata_o  out  STREAM_DATA_WIDTH  buffered payload
m_axis_tkeep_o  out  TKEEP_WIDTH  byte enables
m_axis_tvalid_o  out  1  output beat valid
m_axis_tlast_o  out  1  last beat of frame
m_axis_tready_i  in  1  consumer ready
buffer_level_o  out  ADDR_WIDTH+1  beats written and not yet read, including uncommitted beats

Behaviour:
- Reset, asynchronous and active-low:
  - All pointers go to 0 and the write FSM goes to WR_STORE.
  - m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o and m_axis_tkeep_o go to 0; buffer_level_o goes to 0.
  - s_axis_tready_o is 0 while reset is asserted and 1 from the first edge after release.
- Storage: 2^ADDR_WIDTH entries of {tlast, tkeep, tdata}, simple dual-port, written on the accepted beat.
- Pointers are each ADDR_WIDTH+1 bits and wrap naturally:
  - wr_ptr: next write location.
  - commit_ptr: end of the last complete frame.
  - rd_ptr: next read location.
  - used = wr_ptr - rd_ptr, modulo arithmetic; full when used == 2^ADDR_WIDTH.
- Write FSM, advancing on each accepted beat (s_axis_tvalid_i & s_axis_tready_o):
  - WR_STORE, not full: write the beat and increment wr_ptr. If tlast, set commit_ptr = wr_ptr+1.
  - WR_STORE, full: do not write. Rewind wr_ptr to commit_ptr. If tlast, stay in WR_STORE (frame dropped); otherwise go to WR_DROP.
  - WR_DROP: discard beats. On tlast, return to WR_STORE.
  - The full test uses the registered rd_ptr. A read in the same cycle does not rescue the beat (conservative drop).
- Read side, with a single output register:
  - When (!m_axis_tvalid_o | m_axis_tready_i) and rd_ptr != commit_ptr: load the register from mem[rd_ptr], increment rd_ptr, set tvalid to 1.
  - When the register is consumed and there is no committed data: tvalid goes to 0.
- Latency: tlast accepted at edge N gives m_axis_tvalid_o high after edge N+1. Sustained throughput is 1 beat/clock.
- Output stability: while m_axis_tvalid_o & !m_axis_tready_i, all m_axis outputs hold.
- tkeep and tlast pass through unmodified.
- A zero-length frame cannot occur; a single-beat frame with tlast is legal.
- Simultaneous write and read: both proceed, and buffer_level_o reflects both.
- Reset mid-frame: buffered data is lost. Upstream shares the same reset, so no resynchronisation is performed.

Optional Feature:
- Macro UDP_BUF_STATS_EN. When defined, adds two outputs, both reset to 0:
  - frames_ok_o (16 bits): increments on each committed frame; saturates at 0xFFFF.
  - frames_dropped_o (16 bits): increments on the tlast of each dropped frame; saturates at 0xFFFF.
- When not defined, these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared header udp_buffer.vh holds:
  - write FSM state encodings (WR_STORE, WR_DROP);
  - the statistics counter width (16);
  - the default ADDR_WIDTH.
- Sub-module sdp_ram holds the storage:
  - simple dual-port, parameterised width and ADDR_WIDTH;
  - synchronous write, combinational read, so it infers as distributed RAM.

Test Plan:
1. Single 3-beat frame 0x11111111, 0x22222222, 0x33333333 (tkeep 4'hF, tlast on 3rd) with m_tready=1 -> m_tvalid rises after the edge following tlast; 3 identical beats out, tlast on 3rd; buffer_level returns to 0.
2. Two 4-beat frames with m_tready=0 until both are stored, then m_tready toggling every clock -> 8 beats out in order, outputs stable while stalled, no loss.
3. ADDR_WIDTH=4, 20-beat frame -> no output; frames_dropped=1. A following 4-beat frame emerges intact; frames_ok=1.
4. ADDR_WIDTH=4, m_tready=0: 12-beat frame stored, then an 8-beat frame -> 8-beat frame dropped, buffer_level=12. Raise m_tready -> only the 12-beat frame emerges.
5. 2-beat frame whose last beat has tkeep 4'b0011 -> tkeep 4'b0011 reproduced on the output tlast beat.
6. Assert s_rst_n_i mid-output -> m_tvalid 0 immediately; buffer_level 0; counters 0; s_tready 1 after release.

Source files
------------

// File: rtl/axis_udp_payload_buffer_pkg.sv
// Shared definitions for the UDP payload store-and-forward buffer:
// write FSM states, statistics counter width and default depth.
package axis_udp_payload_buffer_pkg;

  typedef enum logic {
    WR_STORE = 1'b0,
    WR_DROP  = 1'b1
  } wr_state_t;

  localparam int STATS_WIDTH        = 16;
  localparam int DEFAULT_ADDR_WIDTH = 9;

endpackage

// File: rtl/axis_udp_payload_buffer_sdp_ram.sv
// Simple dual-port storage: synchronous write, combinational read so it maps
// onto distributed RAM.
module axis_udp_payload_buffer_sdp_ram #(
  parameter int WIDTH      = 37,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_udp_payload_buffer.sv
// Store-and-forward AXI-Stream frame buffer behind udp_filter; frames that do not
// fit are dropped whole. Define UDP_BUF_STATS_EN to add frame ok/drop counters.
module axis_udp_payload_buffer
  import axis_udp_payload_buffer_pkg::*;
#(
  parameter int STREAM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH        = DEFAULT_ADDR_WIDTH,
  localparam int TKEEP_WIDTH      = STREAM_DATA_WIDTH / 8
) (
  input  logic                         clk_i,
  input  logic                         s_rst_n_i,
  input  logic [STREAM_DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [TKEEP_WIDTH-1:0]       s_axis_tkeep_i,
  input  logic                         s_axis_tvalid_i,
  input  logic                         s_axis_tlast_i,
  output logic                         s_axis_tready_o,
  output logic [STREAM_DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic [TKEEP_WIDTH-1:0]       m_axis_tkeep_o,
  output logic                         m_axis_tvalid_o,
  output logic                         m_axis_tlast_o,
  input  logic                         m_axis_tready_i,
  output logic [ADDR_WIDTH:0]          buffer_level_o
`ifdef UDP_BUF_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]       frames_ok_o,
  output logic [STATS_WIDTH-1:0]       frames_dropped_o
`endif
);

  localparam int ENTRY_WIDTH = 1 + TKEEP_WIDTH + STREAM_DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  wr_state_t              wr_state;
  logic [ADDR_WIDTH:0]    wr_ptr;
  logic [ADDR_WIDTH:0]    commit_ptr;
  logic [ADDR_WIDTH:0]    rd_ptr;
  logic [ADDR_WIDTH:0]    used;
  logic                   accept;
  logic                   full;
  logic                   wr_en;
  logic                   commit;
  logic                   drop_done;
  logic                   rd_load;
  logic [ENTRY_WIDTH-1:0] rd_entry;

  // Full is judged on the registered read pointer, so a read in the same
  // cycle never rescues a beat.
  assign accept    = s_axis_tvalid_i & s_axis_tready_o;
  assign used      = wr_ptr - rd_ptr;
  assign full      = used[ADDR_WIDTH];
  assign wr_en     = accept & (wr_state == WR_STORE) & ~full;
  assign commit    = wr_en & s_axis_tlast_i;
  assign drop_done = accept & s_axis_tlast_i & ((wr_state == WR_DROP) | full);
  assign rd_load   = (~m_axis_tvalid_o | m_axis_tready_i) & (rd_ptr != commit_ptr);

  // The beat sitting in the output register still counts as buffered.
  assign buffer_level_o = used + {{ADDR_WIDTH{1'b0}}, m_axis_tvalid_o};

  axis_udp_payload_buffer_sdp_ram #(
    .WIDTH      (ENTRY_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data ({s_axis_tlast_i, s_axis_tkeep_i, s_axis_tdata_i}),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (rd_entry)
  );

  always_ff @(posedge clk_i or negedge s_rst_n_i) begin
    if (!s_rst_n_i) begin
      wr_state        <= WR_STORE;
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      s_axis_tready_o <= 1'b0;
    end else begin
      s_axis_tready_o <= 1'b1;
      if (accept) begin
        case (wr_state)
          WR_STORE: begin
            if (!full) begin
              wr_ptr <= wr_ptr + PTR_ONE;
              if (s_axis_tlast_i) begin
                commit_ptr <= wr_ptr + PTR_ONE;
              end
            end else begin
              // Out of space: forget the partial frame and skip its tail.
              wr_ptr <= commit_ptr;
              if (!s_axis_tlast_i) begin
                wr_state <= WR_DROP;
              end
            end
          end
          WR_DROP: begin
            if (s_axis_tlast_i) begin
              wr_state <= WR_STORE;
            end
          end
          default: wr_state <= WR_STORE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge s_rst_n_i) begin
    if (!s_rst_n_i) begin
      rd_ptr          <= '0;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tlast_o  <= 1'b0;
      m_axis_tkeep_o  <= '0;
      m_axis_tdata_o  <= '0;
    end else if (rd_load) begin
      rd_ptr          <= rd_ptr + PTR_ONE;
      m_axis_tvalid_o <= 1'b1;
      {m_axis_tlast_o, m_axis_tkeep_o, m_axis_tdata_o} <= rd_entry;
    end else if (m_axis_tready_i) begin
      m_axis_tvalid_o <= 1'b0;
    end
  end

`ifdef UDP_BUF_STATS_EN
  always_ff @(posedge clk_i or negedge s_rst_n_i) begin
    if (!s_rst_n_i) begin
      frames_ok_o      <= '0;
      frames_dropped_o <= '0;
    end else begin
      if (commit && (frames_ok_o != '1)) begin
        frames_ok_o <= frames_ok_o + 1'b1;
      end
      if (drop_done && (frames_dropped_o != '1)) begin
        frames_dropped_o <= frames_dropped_o + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_udp_payload_buffer.sv
// Scoreboard bench for axis_udp_payload_buffer with a 16-entry buffer; the
// counter checks are active when UDP_BUF_STATS_EN is defined.
module tb_axis_udp_payload_buffer;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int AW = 4;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [AW:0]   level;
`ifdef UDP_BUF_STATS_EN
  logic [15:0]   frames_ok;
  logic [15:0]   frames_dropped;
`endif

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  beat_t held;
  beat_t got;
  beat_t want;
  bit    stall_prev;

  axis_udp_payload_buffer #(
    .STREAM_DATA_WIDTH (DW),
    .ADDR_WIDTH        (AW)
  ) dut (
    .clk_i            (clk),
    .s_rst_n_i        (rst_n),
    .s_axis_tdata_i   (s_tdata),
    .s_axis_tkeep_i   (s_tkeep),
    .s_axis_tvalid_i  (s_tvalid),
    .s_axis_tlast_i   (s_tlast),
    .s_axis_tready_o  (s_tready),
    .m_axis_tdata_o   (m_tdata),
    .m_axis_tkeep_o   (m_tkeep),
    .m_axis_tvalid_o  (m_tvalid),
    .m_axis_tlast_o   (m_tlast),
    .m_axis_tready_i  (m_tready),
    .buffer_level_o   (level)
`ifdef UDP_BUF_STATS_EN
    ,
    .frames_ok_o      (frames_ok),
    .frames_dropped_o (frames_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                input logic l, input bit expect_out);
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    if (expect_out) exp_q.push_back(beat_t'{last: l, keep: k, data: d});
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [DW-1:0] base,
                            input logic [KW-1:0] last_keep, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(base + DW'(i), (i == n - 1) ? last_keep : 4'hF, i == n - 1, expect_out);
    end
  endtask

  task automatic drain(input string name, input int max_cycles, input bit toggle);
    int c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      if (toggle) m_tready = ~m_tready;
      @(posedge clk); #1;
      c++;
    end
    check_output(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_output({name, "_tvalid"}, 32'(m_tvalid), 32'd0);
    check_output({name, "_level"},  32'(level),    32'd0);
    check_output({name, "_tready"}, 32'(s_tready), 32'd0);
    check_output({name, "_out"},    32'({m_tlast, m_tkeep, m_tdata}), 32'd0);
`ifdef UDP_BUF_STATS_EN
    check_output({name, "_ok"},   32'(frames_ok),      32'd0);
    check_output({name, "_drop"}, 32'(frames_dropped), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check_output({name, "_tready_up"}, 32'(s_tready), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks that a stalled
  // output holds steady.
  initial begin
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        got = beat_t'{last: m_tlast, keep: m_tkeep, data: m_tdata};
        if (stall_prev) begin
          total++;
          if (got !== held) begin
            bad++;
            $display("[TB] FAIL stable: got %0h expected %0h", got, held);
          end
        end
        if (m_tvalid && m_tready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_beat: got %0h expected none", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              bad++;
              $display("[TB] FAIL beat: got %0h expected %0h", got, want);
            end
          end
        end
        stall_prev = m_tvalid && !m_tready;
        held       = got;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    do_reset("rst0");

    // Single 3-beat frame, released one edge after its tlast
    apply_stimulus(32'h11111111, 4'hF, 1'b0, 1'b1);
    apply_stimulus(32'h22222222, 4'hF, 1'b0, 1'b1);
    apply_stimulus(32'h33333333, 4'hF, 1'b1, 1'b1);
    check_output("t1_valid_pre", 32'(m_tvalid), 32'd0);
    @(posedge clk); #1;
    check_output("t1_valid_post", 32'(m_tvalid), 32'd1);
    drain("t1_drain", 20, 1'b0);
    check_output("t1_level", 32'(level), 32'd0);
    check_output("t1_idle", 32'(m_tvalid), 32'd0);

    // Two frames stored while stalled, then drained with toggling ready
    m_tready = 1'b0;
    send_frame(4, 32'hA0000000, 4'hF, 1'b1);
    send_frame(4, 32'hB0000000, 4'hF, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check_output("t2_level", 32'(level), 32'd8);
    check_output("t2_head", m_tdata, 32'hA0000000);
    drain("t2_drain", 40, 1'b1);
    m_tready = 1'b1;
    @(posedge clk); #1;
    check_output("t2_level_end", 32'(level), 32'd0);

    // Oversized frame is dropped whole, following frame survives
    do_reset("rst3");
    send_frame(20, 32'hC0000000, 4'hF, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check_output("t3_novalid", 32'(m_tvalid), 32'd0);
    check_output("t3_level", 32'(level), 32'd0);
`ifdef UDP_BUF_STATS_EN
    check_output("t3_drop", 32'(frames_dropped), 32'd1);
    check_output("t3_ok0", 32'(frames_ok), 32'd0);
`endif
    send_frame(4, 32'hD0000000, 4'hF, 1'b1);
    drain("t3_drain", 20, 1'b0);
`ifdef UDP_BUF_STATS_EN
    check_output("t3_ok", 32'(frames_ok), 32'd1);
`endif

    // 12-beat frame held, 8-beat frame does not fit behind it
    m_tready = 1'b0;
    send_frame(12, 32'hE0000000, 4'hF, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    send_frame(8, 32'hF0000000, 4'hF, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check_output("t4_level", 32'(level), 32'd12);
    check_output("t4_valid", 32'(m_tvalid), 32'd1);
`ifdef UDP_BUF_STATS_EN
    check_output("t4_drop", 32'(frames_dropped), 32'd2);
    check_output("t4_ok", 32'(frames_ok), 32'd2);
`endif
    m_tready = 1'b1;
    drain("t4_drain", 40, 1'b0);
    check_output("t4_level_end", 32'(level), 32'd0);

    // Partial tkeep on the last beat
    apply_stimulus(32'h55AA55AA, 4'hF, 1'b0, 1'b1);
    apply_stimulus(32'h0000BEEF, 4'h3, 1'b1, 1'b1);
    drain("t5_drain", 20, 1'b0);

    // Reset while a frame is being emitted
    m_tready = 1'b0;
    send_frame(4, 32'h12340000, 4'hF, 1'b0);
    begin
      int c = 0;
      while (!m_tvalid && c < 10) begin @(posedge clk); #1; c++; end
    end
    check_output("t6_valid", 32'(m_tvalid), 32'd1);
    exp_q.push_back(beat_t'{last: 1'b0, keep: 4'hF, data: 32'h12340000});
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
    check_output("t6_mid", 32'(m_tvalid), 32'd1);
    check_output("t6_q", 32'(exp_q.size()), 32'd0);
    do_reset("t6_rst");
    check_output("t6_level_after", 32'(level), 32'd0);

    // Single-beat frame after reset
    m_tready = 1'b1;
    apply_stimulus(32'h600DF00D, 4'h1, 1'b1, 1'b1);
    drain("t7_drain", 20, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check_output("t7_level", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
